// File: rtl/seq_alu.sv
// Registered ALU with start/done handshake and a bit-serial shifter.
// Single-cycle ops complete on the next cycle; shifts take one cycle per bit.
module seq_alu #(
    parameter int WIDTH      = 16,
    parameter bit SIGNED_SLT = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op_code,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int M  = WIDTH - 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] sh_next;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    amt;
    logic             dir_right;
    logic             out_bit;
    logic             accept;
    logic             shift_go;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             gt;
    logic [WIDTH-1:0] r_s;
    logic             r_c;
    logic             r_v;

    assign ready    = (state == IDLE);
    assign accept   = start & ready;
    assign shift_go = accept & op_code[2] & op_code[1] & (|a);
    assign amt      = (a >= WIDTH'(WIDTH)) ? CW'(WIDTH) : a[CW-1:0];

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (shift_go) state_next = SHIFT;
            SHIFT:   if (cnt == CW'(1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sum  = {1'b0, a} + {1'b0, b};
        diff = {1'b0, b} - {1'b0, a};
        gt   = SIGNED_SLT ? ($signed(a) > $signed(b)) : (a > b);
        r_s  = '0;
        r_c  = 1'b0;
        r_v  = 1'b0;
        case (op_code)
            3'b010: begin
                r_s = sum[WIDTH-1:0];
                r_c = sum[WIDTH];
                r_v = (a[M] == b[M]) && (r_s[M] != a[M]);
            end
            3'b011: begin
                r_s = diff[WIDTH-1:0];
                r_c = diff[WIDTH];
                r_v = (b[M] != a[M]) && (r_s[M] != b[M]);
            end
            3'b100: r_s = a | b;
            3'b101: r_s[0] = gt;
            // only reached with a==0: shift by zero passes b through
            3'b110, 3'b111: r_s = b;
            default: r_s = '0;
        endcase
    end

    always_comb begin
        if (dir_right) begin
            sh_next = sh >> 1;
            out_bit = sh[0];
        end else begin
            sh_next = sh << 1;
            out_bit = sh[M];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            done      <= 1'b0;
            s         <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b1;
            cnt       <= '0;
            sh        <= '0;
            dir_right <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (shift_go) begin
                    sh        <= b;
                    cnt       <= amt;
                    dir_right <= op_code[0];
                end else if (accept) begin
                    s        <= r_s;
                    carry    <= r_c;
                    overflow <= r_v;
                    zero     <= (r_s == '0);
                    done     <= 1'b1;
                end
            end else begin
                sh  <= sh_next;
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    s        <= sh_next;
                    carry    <= out_bit;
                    overflow <= 1'b0;
                    zero     <= (sh_next == '0);
                    done     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=16, signed slt).
// Vector table for single-cycle ops plus hand sequences for shifts and reset.
module tb_seq_alu;

    logic        clock;
    logic        reset;
    logic        start;
    logic [2:0]  op_code;
    logic [15:0] a;
    logic [15:0] b;
    logic        ready;
    logic        done;
    logic [15:0] s;
    logic        carry;
    logic        overflow;
    logic        zero;

    int pass_cnt  = 0;
    int total_cnt = 0;

    seq_alu #(.WIDTH(16), .SIGNED_SLT(1'b1)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op_code  (op_code),
        .a        (a),
        .b        (b),
        .ready    (ready),
        .done     (done),
        .s        (s),
        .carry    (carry),
        .overflow (overflow),
        .zero     (zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] s;
        logic        c;
        logic        v;
        logic        z;
        logic        cz;
    } vec_t;

    vec_t vt[13];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic run_shift(input string name, input logic [2:0] op,
                             input logic [15:0] ta, input logic [15:0] tb_v,
                             input int exp_lat, input logic [15:0] exp_s,
                             input logic exp_c, input logic exp_z,
                             input bit poke);
        int          lat;
        bit          busy_ok;
        logic [15:0] held;
        op_code = op;
        a       = ta;
        b       = tb_v;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        lat     = 0;
        busy_ok = 1'b1;
        held    = s;
        while (!done && lat < 40) begin
            if (!(ready === 1'b0 && s === held)) busy_ok = 1'b0;
            if (poke) begin
                start   = 1'b1;
                op_code = 3'b010;
                a       = 16'($urandom);
                b       = 16'($urandom);
            end
            tick();
            lat++;
        end
        start = 1'b0;
        chk({name, " latency"}, lat, exp_lat);
        chk({name, " busy"}, busy_ok, 1);
        chk({name, " s"}, s, exp_s);
        chk({name, " carry"}, carry, exp_c);
        chk({name, " overflow"}, overflow, 0);
        chk({name, " zero"}, zero, exp_z);
        chk({name, " ready"}, ready, 1);
        tick();
        chk({name, " done pulse"}, done, 0);
    endtask

    initial begin
        int          lat;
        bit          seen;
        vt[0]  = '{3'b010, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1};
        vt[1]  = '{3'b010, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
        vt[2]  = '{3'b011, 16'h0005, 16'h0003, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[3]  = '{3'b011, 16'h0003, 16'h0005, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[4]  = '{3'b011, 16'h0001, 16'h8000, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b1};
        vt[5]  = '{3'b100, 16'h00F0, 16'h0F0F, 16'h0FFF, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[6]  = '{3'b101, 16'h0001, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[7]  = '{3'b101, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1};
        vt[8]  = '{3'b101, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1};
        vt[9]  = '{3'b110, 16'h0000, 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[10] = '{3'b111, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1};
        vt[11] = '{3'b000, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[12] = '{3'b010, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1};

        reset   = 1'b1;
        start   = 1'b0;
        op_code = 3'b000;
        a       = '0;
        b       = '0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst ready", ready, 1);
        chk("rst done", done, 0);
        chk("rst s", s, 0);
        chk("rst carry", carry, 0);
        chk("rst overflow", overflow, 0);
        chk("rst zero", zero, 1);

        // back-to-back accepts: one done per cycle
        for (int i = 0; i < 13; i++) begin
            op_code = vt[i].op;
            a       = vt[i].a;
            b       = vt[i].b;
            start   = 1'b1;
            tick();
            chk($sformatf("vec%0d done", i), done, 1);
            chk($sformatf("vec%0d ready", i), ready, 1);
            chk($sformatf("vec%0d s", i), s, vt[i].s);
            chk($sformatf("vec%0d carry", i), carry, vt[i].c);
            chk($sformatf("vec%0d overflow", i), overflow, vt[i].v);
            if (vt[i].cz) chk($sformatf("vec%0d zero", i), zero, vt[i].z);
        end
        start = 1'b0;
        tick();
        chk("idle done", done, 0);
        chk("idle hold s", s, 16'h0000);

        run_shift("sll4", 3'b110, 16'd4, 16'h8001, 4, 16'h0010, 1'b0, 1'b0, 1'b0);
        run_shift("slr1", 3'b111, 16'd1, 16'h0003, 1, 16'h0001, 1'b1, 1'b0, 1'b0);
        run_shift("slr20", 3'b111, 16'd20, 16'hFFFF, 16, 16'h0000, 1'b1, 1'b1, 1'b1);

        // new accept in the same cycle as a shift's done
        op_code = 3'b111;
        a       = 16'd2;
        b       = 16'h000C;
        start   = 1'b1;
        tick();
        op_code = 3'b010;
        a       = 16'h0010;
        b       = 16'h0020;
        lat     = 0;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        chk("chain shift lat", lat, 2);
        chk("chain shift s", s, 16'h0003);
        tick();
        start = 1'b0;
        chk("chain add done", done, 1);
        chk("chain add s", s, 16'h0030);

        // reset during a shift aborts it; reset wins over start
        op_code = 3'b110;
        a       = 16'd10;
        b       = 16'h0001;
        start   = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset   = 1'b1;
        start   = 1'b1;
        op_code = 3'b010;
        a       = 16'h0001;
        b       = 16'h0001;
        tick();
        reset = 1'b0;
        start = 1'b0;
        chk("abort done", done, 0);
        chk("abort s", s, 0);
        chk("abort ready", ready, 1);
        chk("abort zero", zero, 1);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) seen = 1'b1;
        end
        chk("abort no done", seen, 0);
        op_code = 3'b010;
        a       = 16'h0003;
        b       = 16'h0004;
        start   = 1'b1;
        tick();
        start = 1'b0;
        chk("post add done", done, 1);
        chk("post add s", s, 16'h0007);
        chk("post add zero", zero, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
